// File: rtl/sum_uart_tx.sv
// Adds two latched operand nibbles, captures the WIDTH+1 bit sum and sends it
// as one UART 8N1 frame (start, 8 data bits LSB first, stop) on a registered tx pin.
module sum_uart_tx #(
    parameter int WIDTH        = 4,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             send,
    output logic             tx,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   sum_out
);

    localparam logic [1:0]  IDLE      = 2'd0;
    localparam logic [1:0]  START     = 2'd1;
    localparam logic [1:0]  DATA      = 2'd2;
    localparam logic [1:0]  STOP      = 2'd3;
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    logic [1:0]     state_q,  state_d;
    logic [15:0]    baud_q,   baud_d;
    logic [2:0]     bitIdx_q, bitIdx_d;
    logic [7:0]     shift_q,  shift_d;
    logic [WIDTH:0] sum_q,    sum_d;
    logic           tx_q,     tx_d;
    logic           busy_q,   busy_d;
    logic           done_q,   done_d;

    logic [WIDTH:0] sumNext;
    logic           bitEnd;
    logic           accept;

    assign sumNext = (WIDTH+1)'(a) + (WIDTH+1)'(b);
    assign bitEnd  = (baud_q == BAUD_LAST);

    // A request is taken in IDLE, or on the last STOP cycle so that a held
    // send produces frames with no idle gap (done still pulses for the old frame).
    assign accept  = send && ((state_q == IDLE) || ((state_q == STOP) && bitEnd));

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q + 16'd1;
        bitIdx_d = bitIdx_q;
        shift_d  = shift_q;
        sum_d    = sum_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                baud_d = 16'd0;
            end
            START: begin
                if (bitEnd) begin
                    state_d  = DATA;
                    bitIdx_d = 3'd0;
                    baud_d   = 16'd0;
                end
            end
            DATA: begin
                if (bitEnd) begin
                    baud_d = 16'd0;
                    if (bitIdx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bitIdx_d = bitIdx_q + 3'd1;
                    end
                end
            end
            default: begin
                if (bitEnd) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    baud_d  = 16'd0;
                end
            end
        endcase

        if (accept) begin
            state_d  = START;
            baud_d   = 16'd0;
            bitIdx_d = 3'd0;
            sum_d    = sumNext;
            shift_d  = 8'(sumNext);
        end

        // Line level is derived from the next state so tx lands on the same edge as the state.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[bitIdx_d];
            default: tx_d = 1'b1;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            baud_q   <= 16'd0;
            bitIdx_q <= 3'd0;
            shift_q  <= 8'd0;
            sum_q    <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bitIdx_q <= bitIdx_d;
            shift_q  <= shift_d;
            sum_q    <= sum_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign tx      = tx_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign sum_out = sum_q;

endmodule

// File: tb/tb_sum_uart_tx.sv
// Directed bench for sum_uart_tx with CLKS_PER_BIT=4: table of operand/frame
// vectors plus hand-written sequences for ignore, back-to-back and mid-frame reset.
module tb_sum_uart_tx;

    localparam int WIDTH = 4;
    localparam int CPB   = 4;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [4:0] sum;
        logic [7:0] frameByte;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] a = 4'd0;
    logic [3:0] b = 4'd0;
    logic       send = 1'b0;
    logic       tx;
    logic       busy;
    logic       done;
    logic [4:0] sum_out;

    int total = 0;
    int bad   = 0;

    vec_t vecs[5];

    always #5 clk = ~clk;

    sum_uart_tx #(.WIDTH(WIDTH), .CLKS_PER_BIT(CPB)) dut (
        .clk     (clk),
        .reset   (reset),
        .a       (a),
        .b       (b),
        .send    (send),
        .tx      (tx),
        .busy    (busy),
        .done    (done),
        .sum_out (sum_out)
    );

    // Expected tx level per cycle of a frame, bit 0 = first cycle after acceptance.
    function automatic logic [39:0] txWave(input logic [7:0] by);
        logic [39:0] w;
        int j;
        for (int c = 0; c < 40; c++) begin
            j = c / CPB;
            if (j == 0)      w[c] = 1'b0;
            else if (j == 9) w[c] = 1'b1;
            else             w[c] = by[j-1];
        end
        return w;
    endfunction

    task automatic checkOutput(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] av, input logic [3:0] bv);
        @(negedge clk);
        a    = av;
        b    = bv;
        send = 1'b1;
        @(posedge clk);
    endtask

    // Samples 41 cycles after acceptance; optionally pulses send and changes operands mid-frame.
    task automatic observeFrame(input logic [7:0] by, input logic [4:0] expSum,
                                input int pulseAt, input string tag);
        logic [39:0] txA;
        logic [39:0] busyA;
        logic [40:0] doneA;
        logic        busyEnd;
        busyEnd = 1'b1;
        for (int c = 1; c <= 41; c++) begin
            @(negedge clk);
            if (c == 1) send = 1'b0;
            if (pulseAt > 0 && c == pulseAt) begin
                send = 1'b1;
                a    = 4'd15;
                b    = 4'd15;
            end
            if (pulseAt > 0 && c == pulseAt + 1) send = 1'b0;
            if (c <= 40) begin
                txA[c-1]   = tx;
                busyA[c-1] = busy;
            end else begin
                busyEnd = busy;
            end
            doneA[c-1] = done;
        end
        checkOutput({tag, " tx"},      txA,     txWave(by));
        checkOutput({tag, " busy"},    busyA,   {40{1'b1}});
        checkOutput({tag, " busyEnd"}, busyEnd, 1'b0);
        checkOutput({tag, " done"},    doneA,   41'd1 << 40);
        checkOutput({tag, " sum_out"}, sum_out, expSum);
    endtask

    initial begin
        logic [19:0] txI, busyI, doneI;
        logic [79:0] txB;
        logic [81:0] busyB, doneB, expDone;
        logic        anyBusy, anyDone;

        vecs[0] = '{a: 4'd9,  b: 4'd7,  sum: 5'd16, frameByte: 8'h10};
        vecs[1] = '{a: 4'd15, b: 4'd15, sum: 5'd30, frameByte: 8'h1E};
        vecs[2] = '{a: 4'd0,  b: 4'd0,  sum: 5'd0,  frameByte: 8'h00};
        vecs[3] = '{a: 4'd8,  b: 4'd7,  sum: 5'd15, frameByte: 8'h0F};
        vecs[4] = '{a: 4'd1,  b: 4'd2,  sum: 5'd3,  frameByte: 8'h03};

        repeat (3) @(negedge clk);
        reset = 1'b0;

        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            txI[c]   = tx;
            busyI[c] = busy;
            doneI[c] = done;
        end
        checkOutput("idle tx",      txI,     {20{1'b1}});
        checkOutput("idle busy",    busyI,   20'd0);
        checkOutput("idle done",    doneI,   20'd0);
        checkOutput("idle sum_out", sum_out, 5'd0);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b);
            observeFrame(vecs[i].frameByte, vecs[i].sum, 0, $sformatf("vec%0d", i));
            repeat (3) @(negedge clk);
        end

        applyStimulus(4'd3, 4'd4);
        observeFrame(8'h07, 5'd7, 10, "ignore");
        anyBusy = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            anyBusy = anyBusy | busy;
        end
        checkOutput("ignore no queued frame", anyBusy, 1'b0);
        checkOutput("ignore sum_out held",    sum_out, 5'd7);

        @(negedge clk);
        a    = 4'd1;
        b    = 4'd2;
        send = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 82; c++) begin
            @(negedge clk);
            if (c == 41) send = 1'b0;
            if (c <= 80) txB[c-1] = tx;
            busyB[c-1] = busy;
            doneB[c-1] = done;
        end
        expDone     = '0;
        expDone[40] = 1'b1;
        expDone[80] = 1'b1;
        checkOutput("b2b tx",      txB,     {txWave(8'h03), txWave(8'h03)});
        checkOutput("b2b busy",    busyB,   {2'b00, {80{1'b1}}});
        checkOutput("b2b done",    doneB,   expDone);
        checkOutput("b2b sum_out", sum_out, 5'd3);

        applyStimulus(4'd9, 4'd7);
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            if (c == 1) send = 1'b0;
        end
        checkOutput("rst pre tx bit3", tx, 1'b0);
        reset = 1'b1;
        #1;
        checkOutput("rst async tx",   tx,   1'b1);
        checkOutput("rst async busy", busy, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        anyBusy = 1'b0;
        anyDone = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            anyBusy = anyBusy | busy;
            anyDone = anyDone | done;
        end
        checkOutput("rst no done",  anyDone, 1'b0);
        checkOutput("rst no busy",  anyBusy, 1'b0);
        checkOutput("rst sum_out",  sum_out, 5'd0);

        applyStimulus(4'd15, 4'd15);
        observeFrame(8'h1E, 5'd30, 0, "postreset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
